// File: rtl/wb_decode_interconnect.sv
// Single-master Wishbone interconnect: decodes the slave from the top address bits,
// registers the request and runs one transaction at a time. WB_TIMEOUT_EN adds a wait-state limit.
module wb_decode_interconnect #(
    parameter int NUM_SLAVES     = 8,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int IDX_BITS       = 4
`ifdef WB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 256
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m_cyc_i,
    input  logic                     m_stb_i,
    input  logic                     m_we_i,
    input  logic [AW-1:0]            m_addr_i,
    input  logic [DW-1:0]            m_data_i,
    input  logic [DW/8-1:0]          m_sel_i,
    output logic [DW-1:0]            m_data_o,
    output logic                     m_ack_o,
    output logic                     m_err_o,
    output logic [NUM_SLAVES-1:0]    s_cyc_o,
    output logic [NUM_SLAVES-1:0]    s_stb_o,
    output logic                     s_we_o,
    output logic [AW-1:0]            s_addr_o,
    output logic [DW-1:0]            s_data_o,
    output logic [DW/8-1:0]          s_sel_o,
    input  logic [NUM_SLAVES*DW-1:0] s_data_i,
    input  logic [NUM_SLAVES-1:0]    s_ack_i
);

    localparam int SW = DW / 8;

    // S_DECERR holds an unmapped request for one cycle so err arrives with the same latency as ack.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DECERR = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;

    logic                    r_we;
    logic [AW-1:0]           r_addr;
    logic [DW-1:0]           r_wdata;
    logic [SW-1:0]           r_sel;
    logic [NUM_SLAVES-1:0]   r_slv_oh;
    logic [DW-1:0]           r_rdata;
    logic                    r_ack;
    logic                    r_err;

    logic                    w_req;
    logic [IDX_BITS-1:0]     w_idx;
    logic [NUM_SLAVES-1:0]   w_dec_oh;
    logic                    w_mapped;
    logic                    w_slv_ack;
    logic                    w_timeout;
    logic [DW-1:0]           w_rd_terms [NUM_SLAVES];
    logic [DW-1:0]           w_rdata;

    logic                    w_latch;
    logic                    w_clr_oh;
    logic                    w_set_ack;
    logic                    w_set_err;

    assign w_req = m_cyc_i & m_stb_i;
    assign w_idx = m_addr_i[AW-1 -: IDX_BITS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
            assign w_dec_oh[gi]   = (w_idx == IDX_BITS'(gi));
            assign w_rd_terms[gi] = s_data_i[gi*DW +: DW] & {DW{r_slv_oh[gi]}};
        end
    endgenerate

    // An index with no matching slave bit is unmapped.
    assign w_mapped  = |w_dec_oh;
    assign w_slv_ack = |(s_ack_i & r_slv_oh);

    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            w_rdata = w_rdata | w_rd_terms[i];
        end
    end

`ifdef WB_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TCW-1:0] r_tcnt;

    // Held at zero outside ACCESS, so it starts from zero on every entry; saturates at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tcnt <= '0;
        end else if (r_state != S_ACCESS) begin
            r_tcnt <= '0;
        end else if (r_tcnt != '1) begin
            r_tcnt <= r_tcnt + TCW'(1);
        end
    end

    assign w_timeout = (r_tcnt == TCW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Priority in ACCESS: abort, then slave ack, then timeout.
    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_clr_oh     = 1'b0;
        w_set_ack    = 1'b0;
        w_set_err    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_latch      = 1'b1;
                    w_state_next = w_mapped ? S_ACCESS : S_DECERR;
                end
            end
            S_ACCESS: begin
                if (!m_cyc_i) begin
                    w_clr_oh     = 1'b1;
                    w_state_next = S_IDLE;
                end else if (w_slv_ack) begin
                    w_clr_oh     = 1'b1;
                    w_set_ack    = 1'b1;
                    w_state_next = S_RESP;
                end else if (w_timeout) begin
                    w_clr_oh     = 1'b1;
                    w_set_err    = 1'b1;
                    w_state_next = S_RESP;
                end
            end
            S_DECERR: begin
                w_set_err    = 1'b1;
                w_state_next = S_RESP;
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_sel    <= '0;
            r_slv_oh <= '0;
            r_rdata  <= '0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_ack   <= w_set_ack;
            r_err   <= w_set_err;
            r_rdata <= (w_set_ack && !r_we) ? w_rdata : '0;
            if (w_latch) begin
                r_we     <= m_we_i;
                r_addr   <= m_addr_i;
                r_wdata  <= m_data_i;
                r_sel    <= m_sel_i;
                r_slv_oh <= w_dec_oh;
            end else if (w_clr_oh) begin
                r_slv_oh <= '0;
            end
        end
    end

    assign m_data_o = r_rdata;
    assign m_ack_o  = r_ack;
    assign m_err_o  = r_err;
    assign s_cyc_o  = r_slv_oh;
    assign s_stb_o  = r_slv_oh;
    assign s_we_o   = r_we;
    assign s_addr_o = r_addr;
    assign s_data_o = r_wdata;
    assign s_sel_o  = r_sel;

endmodule

// File: tb/tb_wb_decode_interconnect.sv
// Self-checking bench for wb_decode_interconnect: directed cases plus randomized transactions
// checked cycle by cycle against latency formulas derived from the bus rules.
module tb_wb_decode_interconnect;

    localparam int NS = 8;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             m_cyc_i = 1'b0;
    logic             m_stb_i = 1'b0;
    logic             m_we_i = 1'b0;
    logic [AW-1:0]    m_addr_i = '0;
    logic [DW-1:0]    m_data_i = '0;
    logic [DW/8-1:0]  m_sel_i = '0;
    logic [DW-1:0]    m_data_o;
    logic             m_ack_o;
    logic             m_err_o;
    logic [NS-1:0]    s_cyc_o;
    logic [NS-1:0]    s_stb_o;
    logic             s_we_o;
    logic [AW-1:0]    s_addr_o;
    logic [DW-1:0]    s_data_o;
    logic [DW/8-1:0]  s_sel_o;
    logic [NS*DW-1:0] s_data_i = '0;
    logic [NS-1:0]    s_ack_i = '0;

    int checks = 0;
    int failures = 0;

    wb_decode_interconnect #(
`ifdef WB_TIMEOUT_EN
        .TIMEOUT_CYCLES(TO),
`endif
        .NUM_SLAVES(NS),
        .AW(AW),
        .DW(DW),
        .IDX_BITS(4)
    ) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_sel_i(m_sel_i),
        .m_data_o(m_data_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o),
        .s_data_i(s_data_i), .s_ack_i(s_ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " stb"}, 64'(s_stb_o), 64'(0));
        chk({tag, " cyc"}, 64'(s_cyc_o), 64'(0));
        chk({tag, " ack"}, 64'(m_ack_o), 64'(0));
        chk({tag, " err"}, 64'(m_err_o), 64'(0));
        chk({tag, " data"}, 64'(m_data_o), 64'(0));
    endtask

    // One request, with the target slave acking after 'waits' ACCESS cycles.
    // Expected timing: strobe on cycles 1..n_acc, response on cycle n_acc+1
    // (unmapped: no strobe, err on cycle 2); cycle 0 is when the request is presented.
    task automatic run_txn(input string tag, input logic [31:0] addr, input logic we,
                           input logic [31:0] wdata, input logic [3:0] sel,
                           input int waits, input logic [31:0] tgt_rdata);
        int          sidx;
        bit          mapped;
        bit          timed_out;
        int          n_acc;
        int          resp_k;
        logic [7:0]  onehot;
        logic [31:0] exp_data;
        logic [7:0]  exp_stb;
        string       t;
        sidx      = int'(addr[31:28]);
        mapped    = (sidx < NS);
        onehot    = mapped ? 8'(1 << sidx) : 8'h00;
        timed_out = 1'b0;
        n_acc     = 0;
        if (mapped) begin
            n_acc = waits + 1;
`ifdef WB_TIMEOUT_EN
            if (waits >= TO) begin
                n_acc     = TO;
                timed_out = 1'b1;
            end
`endif
        end
        resp_k = mapped ? n_acc + 1 : 2;
        for (int i = 0; i < NS; i++) s_data_i[i*DW +: DW] = $urandom();
        if (mapped) s_data_i[sidx*DW +: DW] = tgt_rdata;
        exp_data = (mapped && !timed_out && !we) ? tgt_rdata : 32'h0;
        $display("txn %s addr=%h we=%b waits=%0d sel=%h exp_data=%h %s", tag, addr, we, waits,
                 sel, exp_data, !mapped ? "unmapped" : (timed_out ? "timeout" : "ack"));

        @(negedge clk);
        m_cyc_i  = 1'b1;
        m_stb_i  = 1'b1;
        m_we_i   = we;
        m_addr_i = addr;
        m_data_i = wdata;
        m_sel_i  = sel;
        s_ack_i  = 8'($urandom()) & 8'($urandom()) & ~onehot;
        for (int k = 1; k <= resp_k + 1; k++) begin
            @(negedge clk);
            t = $sformatf("%s k=%0d", tag, k);
            exp_stb = (mapped && k <= n_acc) ? onehot : 8'h00;
            chk({t, " stb"}, 64'(s_stb_o), 64'(exp_stb));
            chk({t, " cyc"}, 64'(s_cyc_o), 64'(exp_stb));
            chk({t, " ack"}, 64'(m_ack_o), 64'(k == resp_k && mapped && !timed_out));
            chk({t, " err"}, 64'(m_err_o), 64'(k == resp_k && (!mapped || timed_out)));
            chk({t, " mdata"}, 64'(m_data_o), 64'((k == resp_k) ? exp_data : 32'h0));
            if (mapped && k <= n_acc) begin
                chk({t, " saddr"}, 64'(s_addr_o), 64'(addr));
                chk({t, " sdata"}, 64'(s_data_o), 64'(wdata));
                chk({t, " ssel"}, 64'(s_sel_o), 64'(sel));
                chk({t, " swe"}, 64'(s_we_o), 64'(we));
            end
            if (k == resp_k) begin
                m_cyc_i = 1'b0;
                m_stb_i = 1'b0;
            end
            s_ack_i = 8'($urandom()) & 8'($urandom()) & ~onehot;
            if (mapped && k <= n_acc && (k - 1) == waits) s_ack_i = s_ack_i | onehot;
        end
        s_ack_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit err_seen;
        bit ack_seen;
        bit stb_lost;

        // Reset state
        repeat (2) @(negedge clk);
        chk_idle("reset");
        chk("reset swe", 64'(s_we_o), 64'(0));
        chk("reset saddr", 64'(s_addr_o), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        chk_idle("post-reset");

        run_txn("read_s2_zw", 32'h2000_0010, 1'b0, 32'h0, 4'hF, 0, 32'hDEADBEEF);
        run_txn("write_s5_w3", 32'h5000_0004, 1'b1, 32'h1234_5678, 4'hC, 3, 32'hCAFE_F00D);
        run_txn("unmapped_A", 32'hA000_0000, 1'b0, 32'h0, 4'hF, 0, 32'h0);
        run_txn("unmapped_F", 32'hF000_0100, 1'b1, 32'h55AA_55AA, 4'h3, 0, 32'h0);
        run_txn("read_s7_w15", 32'h7000_0008, 1'b0, 32'h0, 4'hF, TO - 1, 32'h0BAD_F00D);

`ifdef WB_TIMEOUT_EN
        run_txn("timeout_s1", 32'h1000_0000, 1'b0, 32'h0, 4'hF, 1000, 32'h1111_1111);
        run_txn("timeout_edge", 32'h3000_0000, 1'b0, 32'h0, 4'hF, TO, 32'h2222_2222);
`else
        // Slave 1 never acks: the bus must wait indefinitely, then abort releases it.
        $display("txn hang_s1 addr=10000000 no ack for 1000 cycles then abort");
        @(negedge clk);
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_addr_i = 32'h1000_0000;
        err_seen = 1'b0; ack_seen = 1'b0; stb_lost = 1'b0;
        for (int k = 1; k <= 1000; k++) begin
            @(negedge clk);
            err_seen = err_seen | m_err_o;
            ack_seen = ack_seen | m_ack_o;
            stb_lost = stb_lost | (s_stb_o != 8'h02);
        end
        chk("hang err_seen", 64'(err_seen), 64'(0));
        chk("hang ack_seen", 64'(ack_seen), 64'(0));
        chk("hang stb_lost", 64'(stb_lost), 64'(0));
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        @(negedge clk);
        chk_idle("hang abort");
`endif

        // Abort on 2nd ACCESS cycle with a stray ack from slave 3 while slave 0 is selected.
        $display("txn abort_s0 addr=00000040 stray ack slave3, cyc dropped in 2nd ACCESS cycle");
        @(negedge clk);
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_addr_i = 32'h0000_0040;
        @(negedge clk);
        chk("abort k1 stb", 64'(s_stb_o), 64'(8'h01));
        s_ack_i = 8'h08;
        @(negedge clk);
        chk("abort k2 stb", 64'(s_stb_o), 64'(8'h01));
        chk("abort k2 ack", 64'(m_ack_o), 64'(0));
        s_ack_i = 8'h00;
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        @(negedge clk);
        chk_idle("abort k3");
        @(negedge clk);
        chk_idle("abort k4");

        // Abort coinciding with the selected slave's ack: abort wins.
        $display("txn abort_ack_s6 addr=60000000 ack and cyc drop together");
        @(negedge clk);
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_addr_i = 32'h6000_0000;
        @(negedge clk);
        chk("abortack k1 stb", 64'(s_stb_o), 64'(8'h40));
        m_cyc_i = 1'b0; m_stb_i = 1'b0; s_ack_i = 8'h40;
        @(negedge clk);
        s_ack_i = 8'h00;
        chk_idle("abortack k2");
        @(negedge clk);
        chk_idle("abortack k3");

        // Reset asserted mid-access must clear everything immediately.
        $display("txn reset_mid_s4 addr=40000020 rst during ACCESS");
        @(negedge clk);
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b1; m_addr_i = 32'h4000_0020;
        m_data_i = 32'hA5A5_5A5A; m_sel_i = 4'hF;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid stb before", 64'(s_stb_o), 64'(8'h10));
        rst = 1'b1;
        #1;
        chk_idle("rstmid async");
        chk("rstmid swe", 64'(s_we_o), 64'(0));
        chk("rstmid saddr", 64'(s_addr_o), 64'(0));
        chk("rstmid sdata", 64'(s_data_o), 64'(0));
        chk("rstmid ssel", 64'(s_sel_o), 64'(0));
        @(negedge clk);
        m_cyc_i = 1'b0; m_stb_i = 1'b0;
        rst = 1'b0;
        run_txn("read_s4_after_rst", 32'h4000_0020, 1'b0, 32'h0, 4'hF, 1, 32'h600D_CAFE);

        // Randomized transactions over mapped and unmapped indices.
        for (int n = 0; n < 40; n++) begin
            logic [3:0] sidx;
            sidx = 4'($urandom_range(0, 11));
            run_txn($sformatf("rand%0d", n), {sidx, 28'($urandom())}, 1'($urandom_range(0, 1)),
                    $urandom(), 4'($urandom()), int'($urandom_range(0, 5)), $urandom());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
